// File: rtl/timer_sfr_pkg.sv
// rtl/timer_sfr_pkg.sv - shared constants and state encoding for the timer SFR controller
// Contents:
//   DEFAULT_ADDR_*  default SFR addresses of TCON, TMOD and the TH/TM/TL registers
//   TCON_* / TMOD_* bit positions inside TCON and TMOD
//   chan_state_e    per-timer reload sequencer state
package timer_sfr_pkg;

  localparam logic [7:0] DEFAULT_ADDR_TCON = 8'h88;
  localparam logic [7:0] DEFAULT_ADDR_TMOD = 8'h89;
  localparam logic [7:0] DEFAULT_ADDR_TL0  = 8'h8A;
  localparam logic [7:0] DEFAULT_ADDR_TL1  = 8'h8B;
  localparam logic [7:0] DEFAULT_ADDR_TH0  = 8'h8C;
  localparam logic [7:0] DEFAULT_ADDR_TH1  = 8'h8D;
  localparam logic [7:0] DEFAULT_ADDR_TM0  = 8'h8E;
  localparam logic [7:0] DEFAULT_ADDR_TM1  = 8'h8F;

  localparam int TCON_TF1 = 7;
  localparam int TCON_TR1 = 6;
  localparam int TCON_TF0 = 5;
  localparam int TCON_TR0 = 4;

  localparam int TMOD_GATE1 = 7;
  localparam int TMOD_M1T1  = 5;
  localparam int TMOD_M0T1  = 4;
  localparam int TMOD_GATE0 = 3;
  localparam int TMOD_M1T0  = 1;
  localparam int TMOD_M0T0  = 0;

  typedef enum logic {
    CH_IDLE   = 1'b0,
    CH_COMMIT = 1'b1
  } chan_state_e;

endpackage

// File: rtl/timer_sfr_chan.sv
// rtl/timer_sfr_chan.sv - per-timer shadow/commit, read snapshot and overflow flag
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   th_wr, tm_wr, tl_wr, wdata decoded SFR writes to this timer's byte registers
//   tl_rd                      TL read strobe, captures the live TH/TM snapshot
//   th_i, tm_i                 live counter high/middle bytes
//   ovf, intack                overflow pulse and interrupt acknowledge
//   tcon_wr, tcon_tf           TCON write strobe and the TF bit being written
//   th_o, tm_o, tl_o, load_o   reload value and one-cycle reload strobe
//   tf_o                       registered overflow flag
//   tf_live_o                  flag as seen by a TCON read this cycle
//   snap_th_o, snap_tm_o       snapshot returned by TH/TM reads
module timer_sfr_chan
  import timer_sfr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       th_wr,
  input  logic       tm_wr,
  input  logic       tl_wr,
  input  logic [7:0] wdata,
  input  logic       tl_rd,
  input  logic [7:0] th_i,
  input  logic [7:0] tm_i,
  input  logic       ovf,
  input  logic       intack,
  input  logic       tcon_wr,
  input  logic       tcon_tf,
  output logic [7:0] th_o,
  output logic [7:0] tm_o,
  output logic [7:0] tl_o,
  output logic       load_o,
  output logic       tf_o,
  output logic       tf_live_o,
  output logic [7:0] snap_th_o,
  output logic [7:0] snap_tm_o
);

  chan_state_e state_q, state_d;
  logic [7:0]  shadow_th_q, shadow_tm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CH_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // COMMIT lasts exactly one cycle; a fresh TL write re-enters it so
  // back-to-back writes produce back-to-back load strobes.
  always_comb begin
    state_d = CH_IDLE;
    load_o  = 1'b0;
    case (state_q)
      CH_IDLE: begin
        if (tl_wr) state_d = CH_COMMIT;
      end
      CH_COMMIT: begin
        load_o = 1'b1;
        if (tl_wr) state_d = CH_COMMIT;
      end
      default: state_d = CH_IDLE;
    endcase
  end

  // Shadows keep their value after a commit so only TL must be rewritten
  // to reload the same upper bytes again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_th_q <= 8'h00;
      shadow_tm_q <= 8'h00;
    end else begin
      if (th_wr) shadow_th_q <= wdata;
      if (tm_wr) shadow_tm_q <= wdata;
    end
  end

  // The whole 24-bit reload value changes in the same edge that raises load_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      th_o <= 8'h00;
      tm_o <= 8'h00;
      tl_o <= 8'h00;
    end else if (tl_wr) begin
      th_o <= shadow_th_q;
      tm_o <= shadow_tm_q;
      tl_o <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_th_o <= 8'h00;
      snap_tm_o <= 8'h00;
    end else if (tl_rd) begin
      snap_th_o <= th_i;
      snap_tm_o <= tm_i;
    end
  end

  // Overflow wins over acknowledge, which wins over a software write, so an
  // interrupt is never lost to a clear racing with a new overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tf_o <= 1'b0;
    end else if (ovf) begin
      tf_o <= 1'b1;
    end else if (intack) begin
      tf_o <= 1'b0;
    end else if (tcon_wr) begin
      tf_o <= tcon_tf;
    end
  end

  // A TCON read sees an overflow arriving in the same cycle, but not a
  // concurrent write or acknowledge.
  assign tf_live_o = tf_o | ovf;

endmodule

// File: rtl/timer_sfr_ctrl.sv
// rtl/timer_sfr_ctrl.sv - SFR decode, TCON/TMOD registers and read mux for the dual 24-bit timers
// Ports:
//   timer_sfr_ctrl_machine_cycle_i     clock, one machine cycle
//   timer_sfr_ctrl_reset_i             asynchronous active-low reset
//   sfr_addr_i, sfr_wr_i, sfr_rd_i     SFR bus address and one-cycle strobes
//   sfr_wdata_i                        SFR write data
//   sfr_rdata_o, sfr_rvalid_o          registered read data and one-cycle valid
//   sfr_hit_o                          address decodes to one of the 8 registers
//   tmr0_ovf_i, tmr1_ovf_i             overflow pulses from the timers
//   th0_i..tl1_i                       live counter bytes
//   tmod_o, tr0_o, tr1_o, tcon_lo_o    TMOD, run bits and TCON[3:0]
//   tf0_o, tf1_o                       overflow flags / interrupt requests
//   intack0_i, intack1_i               interrupt vector acknowledge
//   th0_o..tl1_o, load0_o, load1_o     atomic reload values and strobes
module timer_sfr_ctrl
  import timer_sfr_pkg::*;
#(
  parameter logic [7:0] ADDR_TCON = DEFAULT_ADDR_TCON,
  parameter logic [7:0] ADDR_TMOD = DEFAULT_ADDR_TMOD,
  parameter logic [7:0] ADDR_TL0  = DEFAULT_ADDR_TL0,
  parameter logic [7:0] ADDR_TL1  = DEFAULT_ADDR_TL1,
  parameter logic [7:0] ADDR_TH0  = DEFAULT_ADDR_TH0,
  parameter logic [7:0] ADDR_TH1  = DEFAULT_ADDR_TH1,
  parameter logic [7:0] ADDR_TM0  = DEFAULT_ADDR_TM0,
  parameter logic [7:0] ADDR_TM1  = DEFAULT_ADDR_TM1
) (
  input  logic       timer_sfr_ctrl_machine_cycle_i,
  input  logic       timer_sfr_ctrl_reset_i,
  input  logic [7:0] sfr_addr_i,
  input  logic       sfr_wr_i,
  input  logic       sfr_rd_i,
  input  logic [7:0] sfr_wdata_i,
  output logic [7:0] sfr_rdata_o,
  output logic       sfr_rvalid_o,
  output logic       sfr_hit_o,
  input  logic       tmr0_ovf_i,
  input  logic       tmr1_ovf_i,
  input  logic [7:0] th0_i,
  input  logic [7:0] tm0_i,
  input  logic [7:0] tl0_i,
  input  logic [7:0] th1_i,
  input  logic [7:0] tm1_i,
  input  logic [7:0] tl1_i,
  output logic [7:0] tmod_o,
  output logic       tr0_o,
  output logic       tr1_o,
  output logic       tf0_o,
  output logic       tf1_o,
  input  logic       intack0_i,
  input  logic       intack1_i,
  output logic [3:0] tcon_lo_o,
  output logic [7:0] th0_o,
  output logic [7:0] tm0_o,
  output logic [7:0] tl0_o,
  output logic [7:0] th1_o,
  output logic [7:0] tm1_o,
  output logic [7:0] tl1_o,
  output logic       load0_o,
  output logic       load1_o
);

  logic       clk, rst_n;
  logic       hit_tcon, hit_tmod, hit_tl0, hit_tl1, hit_th0, hit_th1, hit_tm0, hit_tm1;
  logic       wr_tcon;
  logic       tf0_live, tf1_live;
  logic [7:0] snap_th0, snap_tm0, snap_th1, snap_tm1;
  logic [7:0] rd_mux;

  assign clk   = timer_sfr_ctrl_machine_cycle_i;
  assign rst_n = timer_sfr_ctrl_reset_i;

  assign hit_tcon = (sfr_addr_i == ADDR_TCON);
  assign hit_tmod = (sfr_addr_i == ADDR_TMOD);
  assign hit_tl0  = (sfr_addr_i == ADDR_TL0);
  assign hit_tl1  = (sfr_addr_i == ADDR_TL1);
  assign hit_th0  = (sfr_addr_i == ADDR_TH0);
  assign hit_th1  = (sfr_addr_i == ADDR_TH1);
  assign hit_tm0  = (sfr_addr_i == ADDR_TM0);
  assign hit_tm1  = (sfr_addr_i == ADDR_TM1);

  assign sfr_hit_o = hit_tcon | hit_tmod | hit_tl0 | hit_tl1 |
                     hit_th0  | hit_th1  | hit_tm0 | hit_tm1;

  assign wr_tcon = sfr_wr_i & hit_tcon;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tr0_o     <= 1'b0;
      tr1_o     <= 1'b0;
      tcon_lo_o <= 4'h0;
    end else if (wr_tcon) begin
      tr0_o     <= sfr_wdata_i[TCON_TR0];
      tr1_o     <= sfr_wdata_i[TCON_TR1];
      tcon_lo_o <= sfr_wdata_i[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmod_o <= 8'h00;
    end else if (sfr_wr_i && hit_tmod) begin
      tmod_o <= sfr_wdata_i;
    end
  end

  timer_sfr_chan u_chan0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .th_wr     (sfr_wr_i & hit_th0),
    .tm_wr     (sfr_wr_i & hit_tm0),
    .tl_wr     (sfr_wr_i & hit_tl0),
    .wdata     (sfr_wdata_i),
    .tl_rd     (sfr_rd_i & hit_tl0),
    .th_i      (th0_i),
    .tm_i      (tm0_i),
    .ovf       (tmr0_ovf_i),
    .intack    (intack0_i),
    .tcon_wr   (wr_tcon),
    .tcon_tf   (sfr_wdata_i[TCON_TF0]),
    .th_o      (th0_o),
    .tm_o      (tm0_o),
    .tl_o      (tl0_o),
    .load_o    (load0_o),
    .tf_o      (tf0_o),
    .tf_live_o (tf0_live),
    .snap_th_o (snap_th0),
    .snap_tm_o (snap_tm0)
  );

  timer_sfr_chan u_chan1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .th_wr     (sfr_wr_i & hit_th1),
    .tm_wr     (sfr_wr_i & hit_tm1),
    .tl_wr     (sfr_wr_i & hit_tl1),
    .wdata     (sfr_wdata_i),
    .tl_rd     (sfr_rd_i & hit_tl1),
    .th_i      (th1_i),
    .tm_i      (tm1_i),
    .ovf       (tmr1_ovf_i),
    .intack    (intack1_i),
    .tcon_wr   (wr_tcon),
    .tcon_tf   (sfr_wdata_i[TCON_TF1]),
    .th_o      (th1_o),
    .tm_o      (tm1_o),
    .tl_o      (tl1_o),
    .load_o    (load1_o),
    .tf_o      (tf1_o),
    .tf_live_o (tf1_live),
    .snap_th_o (snap_th1),
    .snap_tm_o (snap_tm1)
  );

  // Every source is the pre-write register value, so a read colliding with a
  // write to the same address returns the old contents.
  always_comb begin
    rd_mux = 8'h00;
    if (hit_tcon)     rd_mux = {tf1_live, tr1_o, tf0_live, tr0_o, tcon_lo_o};
    else if (hit_tmod) rd_mux = tmod_o;
    else if (hit_tl0)  rd_mux = tl0_i;
    else if (hit_tl1)  rd_mux = tl1_i;
    else if (hit_th0)  rd_mux = snap_th0;
    else if (hit_th1)  rd_mux = snap_th1;
    else if (hit_tm0)  rd_mux = snap_tm0;
    else if (hit_tm1)  rd_mux = snap_tm1;
  end

  // Unmapped reads still complete (rd_mux defaults to zero); rdata holds
  // between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sfr_rdata_o  <= 8'h00;
      sfr_rvalid_o <= 1'b0;
    end else begin
      sfr_rvalid_o <= sfr_rd_i;
      if (sfr_rd_i) sfr_rdata_o <= rd_mux;
    end
  end

endmodule

// File: tb/tb_timer_sfr_ctrl.sv
// tb/tb_timer_sfr_ctrl.sv - directed self-checking bench for timer_sfr_ctrl
module tb_timer_sfr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sfr_addr = 8'h00;
  logic       sfr_wr = 1'b0;
  logic       sfr_rd = 1'b0;
  logic [7:0] sfr_wdata = 8'h00;
  logic [7:0] sfr_rdata;
  logic       sfr_rvalid;
  logic       sfr_hit;
  logic       ovf0 = 1'b0, ovf1 = 1'b0;
  logic [7:0] th0_i = 8'h00, tm0_i = 8'h00, tl0_i = 8'h00;
  logic [7:0] th1_i = 8'h00, tm1_i = 8'h00, tl1_i = 8'h00;
  logic [7:0] tmod;
  logic       tr0, tr1, tf0, tf1;
  logic       ack0 = 1'b0, ack1 = 1'b0;
  logic [3:0] tcon_lo;
  logic [7:0] th0_o, tm0_o, tl0_o, th1_o, tm1_o, tl1_o;
  logic       load0, load1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  timer_sfr_ctrl dut (
    .timer_sfr_ctrl_machine_cycle_i (clk),
    .timer_sfr_ctrl_reset_i         (rst_n),
    .sfr_addr_i   (sfr_addr),
    .sfr_wr_i     (sfr_wr),
    .sfr_rd_i     (sfr_rd),
    .sfr_wdata_i  (sfr_wdata),
    .sfr_rdata_o  (sfr_rdata),
    .sfr_rvalid_o (sfr_rvalid),
    .sfr_hit_o    (sfr_hit),
    .tmr0_ovf_i   (ovf0),
    .tmr1_ovf_i   (ovf1),
    .th0_i        (th0_i),
    .tm0_i        (tm0_i),
    .tl0_i        (tl0_i),
    .th1_i        (th1_i),
    .tm1_i        (tm1_i),
    .tl1_i        (tl1_i),
    .tmod_o       (tmod),
    .tr0_o        (tr0),
    .tr1_o        (tr1),
    .tf0_o        (tf0),
    .tf1_o        (tf1),
    .intack0_i    (ack0),
    .intack1_i    (ack1),
    .tcon_lo_o    (tcon_lo),
    .th0_o        (th0_o),
    .tm0_o        (tm0_o),
    .tl0_o        (tl0_o),
    .th1_o        (th1_o),
    .tm1_o        (tm1_o),
    .tl1_o        (tl1_o),
    .load0_o      (load0),
    .load1_o      (load1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sfr_write(input logic [7:0] addr, input logic [7:0] data);
    sfr_addr = addr; sfr_wdata = data; sfr_wr = 1'b1;
    tick();
    sfr_wr = 1'b0;
  endtask

  task automatic sfr_read(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    sfr_addr = addr; sfr_rd = 1'b1;
    tick();
    sfr_rd = 1'b0;
    check({tag, "_rvalid"}, {31'd0, sfr_rvalid}, 32'd1);
    check({tag, "_rdata"}, {24'd0, sfr_rdata}, {24'd0, exp});
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_rdata", {24'd0, sfr_rdata}, 32'h0);
    check("rst_rvalid", {31'd0, sfr_rvalid}, 32'h0);
    check("rst_reload0", {8'd0, th0_o, tm0_o, tl0_o}, 32'h0);
    check("rst_flags", {28'd0, tf1, tr1, tf0, tr0}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1. Reset in the cycle after a TL0 write discards the commit
    sfr_write(8'h89, 8'hFF);
    check("tmod_ff", {24'd0, tmod}, 32'hFF);
    sfr_addr = 8'h8A; sfr_wdata = 8'h55; sfr_wr = 1'b1;
    @(posedge clk);
    rst_n = 1'b0;
    sfr_wr = 1'b0;
    #1;
    check("rstmid_load0", {31'd0, load0}, 32'h0);
    check("rstmid_tl0", {24'd0, tl0_o}, 32'h0);
    check("rstmid_tmod", {24'd0, tmod}, 32'h0);
    tick();
    check("rstmid_load0_b", {31'd0, load0}, 32'h0);
    rst_n = 1'b1;
    tick();
    check("rstmid_load0_c", {31'd0, load0}, 32'h0);

    // 2. Atomic load
    sfr_write(8'h8C, 8'h12);
    check("th0_wr_noload", {31'd0, load0}, 32'h0);
    sfr_write(8'h8E, 8'h34);
    check("tm0_wr_noload", {31'd0, load0}, 32'h0);
    check("tm0_wr_out_hold", {8'd0, th0_o, tm0_o, tl0_o}, 32'h0);
    sfr_write(8'h8A, 8'h56);
    check("commit_val", {8'd0, th0_o, tm0_o, tl0_o}, 32'h123456);
    check("commit_load", {31'd0, load0}, 32'h1);
    check("commit_load1_quiet", {31'd0, load1}, 32'h0);
    tick();
    check("commit_load_end", {31'd0, load0}, 32'h0);
    check("commit_val_hold", {8'd0, th0_o, tm0_o, tl0_o}, 32'h123456);
    sfr_write(8'h8A, 8'h77);
    check("b2b_first", {7'd0, load0, th0_o, tm0_o, tl0_o}, 32'h1123477);
    sfr_write(8'h8A, 8'h88);
    check("b2b_second", {7'd0, load0, th0_o, tm0_o, tl0_o}, 32'h1123488);
    tick();
    check("b2b_end", {31'd0, load0}, 32'h0);

    // 3. Snapshot coherence
    th0_i = 8'h99; tm0_i = 8'h98;
    sfr_read("th0_nosnap", 8'h8C, 8'h00);
    th1_i = 8'hAA; tm1_i = 8'hBB; tl1_i = 8'hCC;
    sfr_read("tl1_live", 8'h8B, 8'hCC);
    th1_i = 8'h01; tm1_i = 8'h02; tl1_i = 8'h03;
    sfr_read("tm1_snap", 8'h8F, 8'hBB);
    sfr_read("th1_snap", 8'h8D, 8'hAA);

    // 4. Flag priority
    ovf0 = 1'b1; ack0 = 1'b1;
    tick();
    ovf0 = 1'b0; ack0 = 1'b0;
    check("ovf_ack_tf0", {31'd0, tf0}, 32'h1);
    ack0 = 1'b1;
    tick();
    ack0 = 1'b0;
    check("ack_clr_tf0", {31'd0, tf0}, 32'h0);
    ovf1 = 1'b1;
    sfr_write(8'h88, 8'h20);
    ovf1 = 1'b0;
    check("tconwr_ovf1", {30'd0, tf1, tf0}, 32'h3);
    ovf0 = 1'b1;
    sfr_write(8'h88, 8'h00);
    ovf0 = 1'b0;
    check("swclr_vs_ovf", {30'd0, tf1, tf0}, 32'h1);
    sfr_write(8'h88, 8'h00);
    check("swclr_all", {30'd0, tf1, tf0}, 32'h0);
    ovf0 = 1'b1;
    sfr_read("tcon_live_tf0", 8'h88, 8'h20);
    ovf0 = 1'b0;
    ack0 = 1'b1;
    tick();
    ack0 = 1'b0;
    check("ack_clr_tf0_b", {31'd0, tf0}, 32'h0);

    // 5. Read timing, unmapped address, read/write collision
    sfr_write(8'h89, 8'h19);
    check("tmod_19", {24'd0, tmod}, 32'h19);
    sfr_addr = 8'h89; sfr_rd = 1'b1;
    #1;
    check("tmod_rd_noearly", {31'd0, sfr_rvalid}, 32'h0);
    tick();
    sfr_rd = 1'b0;
    check("tmod_rd", {23'd0, sfr_rvalid, sfr_rdata}, 32'h119);
    tick();
    check("tmod_rd_hold", {23'd0, sfr_rvalid, sfr_rdata}, 32'h019);
    sfr_addr = 8'h90;
    #1;
    check("hit_unmapped", {31'd0, sfr_hit}, 32'h0);
    sfr_read("unmapped", 8'h90, 8'h00);
    sfr_addr = 8'h8E;
    #1;
    check("hit_tm0", {31'd0, sfr_hit}, 32'h1);
    sfr_addr = 8'h89; sfr_wdata = 8'h3C; sfr_rd = 1'b1; sfr_wr = 1'b1;
    tick();
    sfr_rd = 1'b0; sfr_wr = 1'b0;
    check("rdwr_old", {23'd0, sfr_rvalid, sfr_rdata}, 32'h119);
    check("rdwr_new_tmod", {24'd0, tmod}, 32'h3C);

    // 6. Run bits
    sfr_write(8'h88, 8'h50);
    check("run_bits", {27'd0, tr1, tr0, tcon_lo}, 32'h30);
    sfr_read("tcon_50", 8'h88, 8'h50);
    sfr_write(8'h88, 8'h0A);
    check("tcon_lo_a", {27'd0, tr1, tr0, tcon_lo}, 32'h0A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
